jesd_lmfc_gen: RTL and testbench
================================

Name: jesd_lmfc_gen

Overview:
- Upstream timing stage for the ADC lane-alignment block.
- Produces the `lmfc_edge` pulse that alignment logic uses to start code-group synchronisation.
- Synchronises the external SYSREF, aligns a local multiframe counter to it with a programmable phase offset, and monitors later SYSREF edges for phase drift.
- Reports lock state and a saturating drift-error count.

Parameters:
- F, 2, octets per frame per lane.
- K, 32, frames per multiframe.
- OCTETS_PER_CLK, 4, octets per lane per clk cycle.
- PERIOD, F*K/OCTETS_PER_CLK (=16), LMFC period in clk cycles. Must be an integer with 2 <= PERIOD <= 256; elaboration error otherwise.

Ports:
- clk  input  1  fabric clock, same domain as the alignment block.
- rst  input  1  synchronous active-high reset.
- sysref  input  1  SYSREF, asynchronous to clk.
- sysref_mode  input  1  0 = one-shot (first edge aligns, later edges only checked); 1 = continuous (every edge re-aligns).
- lmfc_offset  input  8  phase loaded on alignment; values >= PERIOD clamp to PERIOD-1.
- rearm  input  1  one-cycle pulse: drop lock, wait for a new SYSREF.
- lmfc_edge  output  1  one-cycle pulse each multiframe.
- lmfc_cnt  output  8  current multiframe phase, 0..PERIOD-1.
- locked  output  1  counter aligned and running.
- sysref_err  output  1  one-cycle pulse on a misaligned SYSREF while locked.
- err_cnt  output  8  saturating count of sysref_err pulses.

Behaviour:
- Reset values: all outputs 0, synchroniser flops 0, state IDLE.
- The reset values apply for any cycle in which rst is sampled high, including mid-operation.
- Synchroniser: s1 <= sysref, s2 <= s1, s3 <= s2.
- rise = s2 & ~s3. A level held high produces exactly one rise.
- off_c = min(lmfc_offset, PERIOD-1).
- inc = (lmfc_cnt == PERIOD-1) ? 0 : lmfc_cnt + 1.
- States:
  - IDLE: entered from rst; goes to WAIT next cycle. Counter held at 0.
  - WAIT: counter held, locked=0, lmfc_edge=0. On rise: lmfc_cnt <= off_c, locked <= 1, go to LOCKED.
  - LOCKED: lmfc_cnt <= inc every cycle. On rise with inc != off_c: sysref_err <= 1, and err_cnt increments, saturating at 255.
    - Mode 1: lmfc_cnt <= off_c on that same rise (re-align).
    - Mode 0: counter keeps inc (no re-align).
    - Rise with inc == off_c: no error, no change.
- lmfc_edge is registered: lmfc_edge <= (next lmfc_cnt == 0) & next locked. It therefore coincides with lmfc_cnt==0 while locked.
- Latency: sysref first sampled high at edge T gives lmfc_cnt==off_c and locked==1 after edge T+2.
- rearm:
  - In any state, go to WAIT, clear locked, hold counter at 0, clear lmfc_edge next cycle.
  - rearm has priority over a simultaneous rise; that rise is discarded.
  - err_cnt is not cleared by rearm, only by rst.
- sysref_mode and lmfc_offset are sampled only on a rise. Changes between rises have no effect.
- sysref_err is 0 in every cycle without a qualifying rise. It is never asserted in WAIT.

Decomposition:
- Shared package: state encoding (IDLE, WAIT, LOCKED), mode constants (MODE_ONESHOT=0, MODE_CONT=1), and the PERIOD derivation function.
- One sub-module, cdc_sync_rise: 2-FF synchroniser plus rising-edge detector (clk, rst, async_in, rise). It is reusable for other asynchronous strobes.

Test Plan (F=2, K=32, PERIOD=16):
1. Reset, sysref held 0 for 100 cycles -> lmfc_edge never 1, locked=0, lmfc_cnt=0, err_cnt=0.
2. Mode 0, offset 0, sysref high at edge T (held 4 cycles) -> locked=1 and lmfc_edge=1 after T+2. Edges then repeat every 16 cycles; the held level produces no second alignment.
3. Offset 5, sysref at T -> lmfc_cnt=5 after T+2, first lmfc_edge after T+13. Repeat with offset 20 -> clamped to 15, first edge after T+3.
4. Mode 1, sysref every 64 cycles in phase for 5 pulses -> err_cnt=0. Shift the next pulse 3 cycles late -> one sysref_err pulse, err_cnt=1, all later edges 3 cycles later. Continued pulses at the new phase -> no further errors.
5. Mode 0, same 3-cycle shift -> sysref_err pulse, err_cnt=1, edge phase unchanged. 300 misaligned pulses -> err_cnt saturates at 255.
6. rearm in the same cycle as rise -> locked=0 and no edges next cycle, rise ignored. Next sysref relocks with latency 2. rst asserted while locked -> all outputs 0 next cycle.

Source files
------------

// File: rtl/jesd_lmfc_gen_pkg.sv
// Shared definitions for the LMFC generator: FSM encoding, SYSREF mode
// values and the LMFC period derivation used at elaboration.
package jesd_lmfc_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2
  } lmfc_state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  // LMFC period in clk cycles: octets per multiframe over octets per cycle.
  function automatic int lmfc_period(input int f, input int k, input int octets_per_clk);
    return (f * k) / octets_per_clk;
  endfunction

  // The period must divide evenly and fit the 8-bit phase counter.
  function automatic bit lmfc_period_ok(input int f, input int k, input int octets_per_clk);
    int p;
    if (octets_per_clk <= 0) return 1'b0;
    if (((f * k) % octets_per_clk) != 0) return 1'b0;
    p = (f * k) / octets_per_clk;
    return (p >= 2) && (p <= 256);
  endfunction

endpackage

// File: rtl/cdc_sync_rise.sv
// Two-flop synchroniser for an asynchronous strobe plus a rising-edge
// detector on the synchronised level. A held-high input yields one rise.
module cdc_sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  // Synchroniser chain; s3 is the delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Rise is combinational so the consumer sees it one cycle after s2 goes high.
  always_comb rise = s2 & ~s3;

endmodule

// File: rtl/jesd_lmfc_gen.sv
// Local multiframe clock generator. Aligns a phase counter to SYSREF with a
// programmable offset, emits a pulse at phase 0 and tracks SYSREF drift.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | just out of reset, counter held at 0, moves to ST_WAIT
// ST_WAIT   | unlocked, counter held, waiting for a synchronised SYSREF rise
// ST_LOCKED | counter free-running; later rises checked (and in continuous
//           | mode re-aligned)
module jesd_lmfc_gen
  import jesd_lmfc_gen_pkg::*;
#(
  parameter int F              = 2,
  parameter int K              = 32,
  parameter int OCTETS_PER_CLK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sysref,
  input  logic       sysref_mode,
  input  logic [7:0] lmfc_offset,
  input  logic       rearm,
  output logic       lmfc_edge,
  output logic [7:0] lmfc_cnt,
  output logic       locked,
  output logic       sysref_err,
  output logic [7:0] err_cnt
);

  localparam int PERIOD = lmfc_period(F, K, OCTETS_PER_CLK);
  localparam logic [7:0] LAST_PHASE = 8'(PERIOD - 1);

  generate
    if (!lmfc_period_ok(F, K, OCTETS_PER_CLK)) begin : g_bad_period
      $error("jesd_lmfc_gen: F*K/OCTETS_PER_CLK must be an integer in 2..256");
    end
  endgenerate

  logic        rise;
  logic [7:0]  off_c;
  logic [7:0]  inc;
  logic [7:0]  cnt_nxt;
  logic        misalign;
  lmfc_state_e state;

  cdc_sync_rise u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sysref),
    .rise     (rise)
  );

  // Offset clamp and wrapping increment of the phase counter.
  always_comb begin
    off_c = (lmfc_offset > LAST_PHASE) ? LAST_PHASE : lmfc_offset;
    inc   = (lmfc_cnt == LAST_PHASE) ? 8'd0 : lmfc_cnt + 8'd1;
  end

  // Locked-state next phase: a rise off the expected phase is an error, and
  // in continuous mode it also snaps the counter to the offset.
  always_comb begin
    cnt_nxt  = inc;
    misalign = 1'b0;
    if (rise && (inc != off_c)) begin
      misalign = 1'b1;
      if (sysref_mode == MODE_CONT) cnt_nxt = off_c;
    end
  end

  // Alignment FSM with registered outputs; rearm wins over a coincident rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lmfc_cnt   <= 8'd0;
      locked     <= 1'b0;
      lmfc_edge  <= 1'b0;
      sysref_err <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      sysref_err <= 1'b0;
      if (rearm) begin
        state     <= ST_WAIT;
        lmfc_cnt  <= 8'd0;
        locked    <= 1'b0;
        lmfc_edge <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state     <= ST_WAIT;
            lmfc_cnt  <= 8'd0;
            locked    <= 1'b0;
            lmfc_edge <= 1'b0;
          end
          ST_WAIT: begin
            if (rise) begin
              state     <= ST_LOCKED;
              lmfc_cnt  <= off_c;
              locked    <= 1'b1;
              lmfc_edge <= (off_c == 8'd0);
            end else begin
              lmfc_edge <= 1'b0;
            end
          end
          ST_LOCKED: begin
            lmfc_cnt  <= cnt_nxt;
            lmfc_edge <= (cnt_nxt == 8'd0);
            if (misalign) begin
              sysref_err <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
          default: begin
            state     <= ST_IDLE;
            lmfc_cnt  <= 8'd0;
            locked    <= 1'b0;
            lmfc_edge <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jesd_lmfc_gen.sv
// Self-checking bench for jesd_lmfc_gen (PERIOD = 16). A cycle model pushes
// the expected outputs to a queue as each cycle's stimulus is applied; they
// are popped and compared once the DUT has clocked. Directed checks at key
// points use hand-derived constants.
module tb_jesd_lmfc_gen;

  logic       clk = 1'b0;
  logic       rst, sysref, sysref_mode, rearm;
  logic [7:0] lmfc_offset;
  logic       lmfc_edge, locked, sysref_err;
  logic [7:0] lmfc_cnt, err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jesd_lmfc_gen #(.F(2), .K(32), .OCTETS_PER_CLK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sysref      (sysref),
    .sysref_mode (sysref_mode),
    .lmfc_offset (lmfc_offset),
    .rearm       (rearm),
    .lmfc_edge   (lmfc_edge),
    .lmfc_cnt    (lmfc_cnt),
    .locked      (locked),
    .sysref_err  (sysref_err),
    .err_cnt     (err_cnt)
  );

  typedef struct {
    int cnt;
    int lck;
    int edg;
    int err;
    int ecnt;
  } exp_t;

  exp_t sb_q[$];

  // reference model state
  logic m_s1 = 0, m_s2 = 0, m_s3 = 0;
  int   m_st = 0;  // 0 idle, 1 wait, 2 locked
  int   m_cnt = 0, m_locked = 0, m_edge = 0, m_err = 0, m_ecnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Advance model and DUT by one clock with the currently driven inputs.
  task automatic tick();
    exp_t e, got;
    int   off, inc;
    logic rise;
    rise  = m_s2 && !m_s3;
    off   = (lmfc_offset > 8'd15) ? 15 : int'(lmfc_offset);
    inc   = (m_cnt + 1) % 16;
    m_err = 0;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      m_st = 0; m_cnt = 0; m_locked = 0; m_edge = 0; m_ecnt = 0;
    end else begin
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = sysref;
      if (rearm) begin
        m_st = 1; m_cnt = 0; m_locked = 0;
      end else if (m_st == 0) begin
        m_st = 1; m_cnt = 0; m_locked = 0;
      end else if (m_st == 1) begin
        if (rise) begin
          m_st = 2; m_cnt = off; m_locked = 1;
        end
      end else begin
        if (rise && inc != off) begin
          m_err = 1;
          if (m_ecnt < 255) m_ecnt++;
          m_cnt = sysref_mode ? off : inc;
        end else begin
          m_cnt = inc;
        end
      end
      m_edge = (m_locked == 1 && m_cnt == 0) ? 1 : 0;
    end
    e.cnt = m_cnt; e.lck = m_locked; e.edg = m_edge; e.err = m_err; e.ecnt = m_ecnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_eq("sb_lmfc_cnt",   32'(lmfc_cnt),   32'(got.cnt));
    check_eq("sb_locked",     32'(locked),     32'(got.lck));
    check_eq("sb_lmfc_edge",  32'(lmfc_edge),  32'(got.edg));
    check_eq("sb_sysref_err", 32'(sysref_err), 32'(got.err));
    check_eq("sb_err_cnt",    32'(err_cnt),    32'(got.ecnt));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle SYSREF pulse followed by idle cycles; gap cycles in total.
  task automatic pulse(input int gap);
    sysref = 1'b1;
    tick();
    sysref = 1'b0;
    run(gap - 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(3);
  endtask

  initial begin
    rst = 1'b1; sysref = 1'b0; sysref_mode = 1'b0; rearm = 1'b0; lmfc_offset = 8'd0;

    // 1: reset and quiet SYSREF
    tick();
    check_eq("rst_locked", 32'(locked), 0);
    check_eq("rst_cnt", 32'(lmfc_cnt), 0);
    rst = 1'b0;
    run(100);
    check_eq("idle_locked", 32'(locked), 0);
    check_eq("idle_cnt", 32'(lmfc_cnt), 0);
    check_eq("idle_errcnt", 32'(err_cnt), 0);

    // 2: one-shot, offset 0, SYSREF held 4 cycles
    sysref = 1'b1;
    tick();                                   // T
    tick();                                   // T+1
    check_eq("lock_lat_t1", 32'(locked), 0);
    tick();                                   // T+2
    check_eq("lock_lat_t2", 32'(locked), 1);
    check_eq("lock_edge_t2", 32'(lmfc_edge), 1);
    check_eq("lock_cnt_t2", 32'(lmfc_cnt), 0);
    tick();                                   // T+3
    sysref = 1'b0;
    lmfc_offset = 8'd9;                       // no rise: must not matter
    sysref_mode = 1'b1;
    run(15);                                  // T+18
    check_eq("period_edge1", 32'(lmfc_edge), 1);
    check_eq("period_cnt1", 32'(lmfc_cnt), 0);
    lmfc_offset = 8'd0;
    sysref_mode = 1'b0;
    run(16);                                  // T+34
    check_eq("period_edge2", 32'(lmfc_edge), 1);
    check_eq("held_no_err", 32'(err_cnt), 0);

    // 3: offset 5, then offset 20 (clamped to 15)
    rearm = 1'b1; tick(); rearm = 1'b0;
    check_eq("rearm_unlock", 32'(locked), 0);
    lmfc_offset = 8'd5;
    sysref = 1'b1; tick(); sysref = 1'b0;     // T
    tick(); tick();                           // T+2
    check_eq("off5_cnt", 32'(lmfc_cnt), 5);
    check_eq("off5_edge_t2", 32'(lmfc_edge), 0);
    run(10);                                  // T+12
    check_eq("off5_edge_t12", 32'(lmfc_edge), 0);
    tick();                                   // T+13
    check_eq("off5_edge_t13", 32'(lmfc_edge), 1);
    rearm = 1'b1; tick(); rearm = 1'b0;
    lmfc_offset = 8'd20;
    sysref = 1'b1; tick(); sysref = 1'b0;
    tick(); tick();                           // T+2
    check_eq("off20_cnt", 32'(lmfc_cnt), 15);
    tick();                                   // T+3
    check_eq("off20_edge", 32'(lmfc_edge), 1);

    // 4: continuous mode, in-phase pulses then a 3-cycle shift
    rearm = 1'b1; tick(); rearm = 1'b0;
    sysref_mode = 1'b1; lmfc_offset = 8'd0;
    for (int i = 0; i < 5; i++) pulse(64);
    check_eq("cont_inphase_errcnt", 32'(err_cnt), 0);
    run(3);
    sysref = 1'b1; tick(); sysref = 1'b0;     // P
    tick(); tick();                           // P+2
    check_eq("cont_shift_err", 32'(sysref_err), 1);
    check_eq("cont_shift_errcnt", 32'(err_cnt), 1);
    check_eq("cont_realign_edge", 32'(lmfc_edge), 1);
    run(61);
    for (int i = 0; i < 3; i++) pulse(64);
    check_eq("cont_newphase_errcnt", 32'(err_cnt), 1);

    // 5: one-shot mode, 3-cycle shift then saturation
    do_reset();
    sysref_mode = 1'b0; lmfc_offset = 8'd0;
    for (int i = 0; i < 3; i++) pulse(64);
    run(3);
    sysref = 1'b1; tick(); sysref = 1'b0;     // P
    tick(); tick();                           // P+2
    check_eq("os_shift_err", 32'(sysref_err), 1);
    check_eq("os_shift_errcnt", 32'(err_cnt), 1);
    check_eq("os_shift_cnt", 32'(lmfc_cnt), 3);
    run(13);
    check_eq("os_phase_kept", 32'(lmfc_edge), 1);
    for (int i = 0; i < 300; i++) pulse(17);
    check_eq("os_saturate", 32'(err_cnt), 255);

    // 6: rearm against a coincident rise, relock, reset while locked
    do_reset();
    pulse(20);
    check_eq("r6_locked", 32'(locked), 1);
    sysref = 1'b1; tick(); sysref = 1'b0;     // T
    tick();                                   // T+1
    rearm = 1'b1; tick(); rearm = 1'b0;       // T+2, rise present
    check_eq("rearm_rise_locked", 32'(locked), 0);
    check_eq("rearm_rise_edge", 32'(lmfc_edge), 0);
    run(20);
    check_eq("rearm_rise_ignored", 32'(locked), 0);
    sysref = 1'b1; tick(); sysref = 1'b0;
    tick();
    check_eq("relock_t1", 32'(locked), 0);
    tick();
    check_eq("relock_t2", 32'(locked), 1);
    check_eq("relock_edge", 32'(lmfc_edge), 1);
    run(5);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("mid_rst_locked", 32'(locked), 0);
    check_eq("mid_rst_cnt", 32'(lmfc_cnt), 0);
    check_eq("mid_rst_edge", 32'(lmfc_edge), 0);
    check_eq("mid_rst_err", 32'(sysref_err), 0);
    check_eq("mid_rst_errcnt", 32'(err_cnt), 0);
    run(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
